// File: rtl/exec_pkg.sv
// Shared constants and state encoding for the execute-stage sequencer.
package exec_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned CNT_W_DEF  = 4;
    localparam int unsigned OP_W_DEF   = 3;

    localparam int unsigned FLAG_W = 3;
    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_C = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/ccr_reg.sv
// Condition-code register {C,N,Z}; EXEC_CCR_SHADOW_EN adds a shadow copy with save/restore.
module ccr_reg
    import exec_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [FLAG_W-1:0] i_d,
`ifdef EXEC_CCR_SHADOW_EN
    input  logic              i_save,
    input  logic              i_restore,
`endif
    output logic [FLAG_W-1:0] o_flags
);

    logic [FLAG_W-1:0] r_flags;

`ifdef EXEC_CCR_SHADOW_EN
    logic [FLAG_W-1:0] r_shadow;

    // Restore beats a same-cycle ALU update; save+restore swaps the two registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flags  <= '0;
            r_shadow <= '0;
        end else begin
            if (i_restore) begin
                r_flags <= r_shadow;
            end else if (i_we) begin
                r_flags <= i_d;
            end
            if (i_save) begin
                r_shadow <= r_flags;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flags <= '0;
        end else if (i_we) begin
            r_flags <= i_d;
        end
    end
`endif

    assign o_flags = r_flags;

endmodule

// File: rtl/exec_seq_ctrl.sv
// Execute-stage ALU sequencer: single-cycle pass-through and repeated single-bit shift steps.
// Optional CCR shadow save/restore ports are enabled with EXEC_CCR_SHADOW_EN.
module exec_seq_ctrl
    import exec_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned OP_W   = OP_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              issue_valid,
    input  logic [OP_W-1:0]   issue_op,
    input  logic              issue_multi,
    input  logic [CNT_W-1:0]  issue_shamt,
    input  logic              issue_flag_we,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [FLAG_W-1:0] alu_flags,
`ifdef EXEC_CCR_SHADOW_EN
    input  logic              ccr_save,
    input  logic              ccr_restore,
`endif
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              stall,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic [FLAG_W-1:0] flags
);

    state_t            r_state;
    logic [DATA_W-1:0] r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic [OP_W-1:0]   r_op;
    logic              r_flag_we;
    logic              r_res_valid;
    logic [DATA_W-1:0] r_res_data;

    logic w_idle_single;
    logic w_idle_last;
    logic w_busy_last;
    logic w_ccr_we;

    assign w_idle_single = (r_state == ST_IDLE) && issue_valid && !issue_multi;
    assign w_idle_last   = (r_state == ST_IDLE) && issue_valid && issue_multi
                           && (issue_shamt == CNT_W'(1));
    assign w_busy_last   = (r_state == ST_BUSY) && (r_cnt <= CNT_W'(1));

    // CCR is touched only when an ALU step completes an instruction.
    assign w_ccr_we = !flush && (((w_idle_single || w_idle_last) && issue_flag_we)
                                 || (w_busy_last && r_flag_we));

    // ALU operand steering and the front-end stall; all forced low while in reset.
    always_comb begin
        alu_op = '0;
        alu_a  = '0;
        alu_b  = '0;
        stall  = 1'b0;
        if (rst) begin
            if (r_state == ST_BUSY) begin
                alu_op = r_op;
                alu_a  = r_acc;
                alu_b  = DATA_W'(1);
                stall  = (r_cnt >= CNT_W'(2)) && !flush;
            end else if (issue_valid && !issue_multi) begin
                alu_op = issue_op;
                alu_a  = op_a;
                alu_b  = op_b;
            end else if (issue_valid && (issue_shamt != '0)) begin
                alu_op = issue_op;
                alu_a  = op_a;
                alu_b  = DATA_W'(1);
                stall  = (issue_shamt >= CNT_W'(2)) && !flush;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_op        <= '0;
            r_flag_we   <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else if (flush) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_res_valid <= 1'b0;
        end else begin
            r_res_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (issue_valid) begin
                        if (!issue_multi) begin
                            r_res_data  <= alu_result;
                            r_res_valid <= 1'b1;
                        end else if (issue_shamt == '0) begin
                            r_res_data  <= op_a;
                            r_res_valid <= 1'b1;
                        end else begin
                            r_acc     <= alu_result;
                            r_cnt     <= issue_shamt - CNT_W'(1);
                            r_op      <= issue_op;
                            r_flag_we <= issue_flag_we;
                            if (issue_shamt == CNT_W'(1)) begin
                                r_res_data  <= alu_result;
                                r_res_valid <= 1'b1;
                            end else begin
                                r_state <= ST_BUSY;
                            end
                        end
                    end
                end
                ST_BUSY: begin
                    r_acc <= alu_result;
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                    if (r_cnt <= CNT_W'(1)) begin
                        r_state     <= ST_IDLE;
                        r_res_data  <= alu_result;
                        r_res_valid <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;

    ccr_reg u_ccr (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_ccr_we),
        .i_d       (alu_flags),
`ifdef EXEC_CCR_SHADOW_EN
        .i_save    (ccr_save),
        .i_restore (ccr_restore),
`endif
        .o_flags   (flags)
    );

endmodule

// File: tb/tb_exec_seq_ctrl.sv
// Bench for exec_seq_ctrl: directed vector table, corner sequences and randomized model comparison.
module tb_exec_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        issue_valid;
    logic [2:0]  issue_op;
    logic        issue_multi;
    logic [3:0]  issue_shamt;
    logic        issue_flag_we;
    logic [15:0] op_a, op_b, alu_result;
    logic [2:0]  alu_flags;
    logic [2:0]  alu_op;
    logic [15:0] alu_a, alu_b;
    logic        stall, res_valid;
    logic [15:0] res_data;
    logic [2:0]  flags;
`ifdef EXEC_CCR_SHADOW_EN
    logic        ccr_save, ccr_restore;
`endif

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [2:0]  m_ccr;

    always #5 clk = ~clk;

    exec_seq_ctrl dut (
        .clk(clk), .rst(rst), .flush(flush), .issue_valid(issue_valid),
        .issue_op(issue_op), .issue_multi(issue_multi), .issue_shamt(issue_shamt),
        .issue_flag_we(issue_flag_we), .op_a(op_a), .op_b(op_b),
        .alu_result(alu_result), .alu_flags(alu_flags),
`ifdef EXEC_CCR_SHADOW_EN
        .ccr_save(ccr_save), .ccr_restore(ccr_restore),
`endif
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .stall(stall),
        .res_valid(res_valid), .res_data(res_data), .flags(flags)
    );

    // Behavioural ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 PASS-B; returns {C,N,Z,result}.
    function automatic logic [18:0] alu_fn(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
        logic [16:0] w;
        logic [15:0] r;
        logic        c;
        w = '0; r = '0; c = 1'b0;
        case (op)
            3'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[15:0]; c = w[16]; end
            3'd1: begin r = a - b; c = (a < b); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin w = {1'b0, a} << b[3:0]; r = w[15:0]; c = w[16]; end
            3'd6: begin w = {a, 1'b0} >> b[3:0]; r = w[16:1]; c = w[0]; end
            default: r = b;
        endcase
        return {c, r[15], (r == 16'd0), r};
    endfunction

    assign {alu_flags, alu_result} = alu_fn(alu_op, alu_a, alu_b);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One instruction: nstall stall cycles, then result/flags one cycle after the last step.
    task automatic run_instr(input logic [2:0] op, input logic multi, input logic [3:0] shamt,
                             input logic fwe, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] exp_res, input logic [2:0] exp_flags,
                             input int nstall, input bit garbage);
        logic [15:0] x;
        logic [18:0] r;
        x = a;
        for (int c = 0; c <= nstall; c++) begin
            @(negedge clk);
            if (c == 0) begin
                issue_valid = 1'b1; issue_op = op; issue_multi = multi;
                issue_shamt = shamt; issue_flag_we = fwe; op_a = a; op_b = b;
            end else if (garbage) begin
                issue_valid = 1'($urandom); issue_op = 3'($urandom);
                issue_multi = 1'($urandom); issue_shamt = 4'($urandom);
                issue_flag_we = 1'($urandom); op_a = 16'($urandom); op_b = 16'($urandom);
            end
            #1;
            chk("stall", 32'(stall), 32'(c < nstall));
            if (c > 0) chk("res_valid_busy", 32'(res_valid), 32'd0);
            if (multi && shamt != 4'd0) begin
                chk("alu_a_step", 32'(alu_a), 32'(x));
                chk("alu_b_step", 32'(alu_b), 32'd1);
                chk("alu_op_step", 32'(alu_op), 32'(op));
                r = alu_fn(op, x, 16'd1);
                x = r[15:0];
            end else if (!multi) begin
                chk("alu_a_single", 32'(alu_a), 32'(a));
                chk("alu_b_single", 32'(alu_b), 32'(b));
            end
        end
        @(posedge clk); #1;
        chk("res_valid", 32'(res_valid), 32'd1);
        chk("res_data", 32'(res_data), 32'(exp_res));
        chk("flags", 32'(flags), 32'(exp_flags));
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        issue_valid = 1'b0; issue_op = 3'($urandom); op_a = 16'($urandom); op_b = 16'($urandom);
        #1;
        chk("idle_stall", 32'(stall), 32'd0);
        chk("idle_alu_op", 32'(alu_op), 32'd0);
        chk("idle_alu_a", 32'(alu_a), 32'd0);
        @(posedge clk); #1;
        chk("idle_res_valid", 32'(res_valid), 32'd0);
        chk("idle_flags", 32'(flags), 32'(m_ccr));
    endtask

    // Reference: single op = one ALU evaluation; shift = shamt repeated 1-bit evaluations.
    task automatic rand_instr();
        logic [2:0]  op;
        logic        multi, fwe;
        logic [3:0]  shamt;
        logic [15:0] a, b, x;
        logic [18:0] r;
        int          nst;
        op = 3'($urandom); multi = 1'($urandom); shamt = 4'($urandom);
        fwe = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
        if (!multi) begin
            r = alu_fn(op, a, b);
            x = r[15:0];
            if (fwe) m_ccr = r[18:16];
        end else begin
            x = a;
            r = '0;
            for (int k = 0; k < int'(shamt); k++) begin
                r = alu_fn(op, x, 16'd1);
                x = r[15:0];
            end
            if (fwe && shamt != 4'd0) m_ccr = r[18:16];
        end
        nst = (multi && shamt > 4'd1) ? int'(shamt) - 1 : 0;
        run_instr(op, multi, shamt, fwe, a, b, x, m_ccr, nst, 1'b1);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic        multi;
        logic [3:0]  shamt;
        logic        fwe;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [2:0]  flg;
        int          nstall;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{3'd1, 1'b0, 4'd0,  1'b1, 16'h0005, 16'h0005, 16'h0000, 3'b001, 0};
        vecs[1] = '{3'd0, 1'b0, 4'd0,  1'b1, 16'h0003, 16'h0005, 16'h0008, 3'b000, 0};
        vecs[2] = '{3'd0, 1'b0, 4'd0,  1'b1, 16'hFFFF, 16'h0001, 16'h0000, 3'b101, 0};
        vecs[3] = '{3'd5, 1'b1, 4'd3,  1'b1, 16'h8001, 16'h0000, 16'h0008, 3'b000, 2};
        vecs[4] = '{3'd5, 1'b1, 4'd0,  1'b1, 16'h1234, 16'h0000, 16'h1234, 3'b000, 0};
        vecs[5] = '{3'd6, 1'b1, 4'd1,  1'b1, 16'h0003, 16'h0000, 16'h0001, 3'b100, 0};
        vecs[6] = '{3'd5, 1'b1, 4'd15, 1'b0, 16'h0001, 16'h0000, 16'h8000, 3'b100, 14};
        vecs[7] = '{3'd5, 1'b1, 4'd2,  1'b1, 16'hC000, 16'h0000, 16'h0000, 3'b101, 1};
        vecs[8] = '{3'd4, 1'b0, 4'd0,  1'b1, 16'hF0F0, 16'h0FF0, 16'hFF00, 3'b010, 0};
        vecs[9] = '{3'd2, 1'b0, 4'd0,  1'b0, 16'h00FF, 16'hFF00, 16'h0000, 3'b010, 0};

        rst = 1'b0; flush = 1'b0; issue_valid = 1'b1; issue_op = 3'd3; issue_multi = 1'b0;
        issue_shamt = 4'd0; issue_flag_we = 1'b0; op_a = 16'h1111; op_b = 16'h2222;
`ifdef EXEC_CCR_SHADOW_EN
        ccr_save = 1'b0; ccr_restore = 1'b0;
`endif
        m_ccr = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        @(negedge clk);
        rst = 1'b1; issue_valid = 1'b0;
        idle_cycle();

        // Directed table, back-to-back with no idle cycles in between.
        foreach (vecs[i])
            run_instr(vecs[i].op, vecs[i].multi, vecs[i].shamt, vecs[i].fwe, vecs[i].a,
                      vecs[i].b, vecs[i].res, vecs[i].flg, vecs[i].nstall, 1'b0);
        m_ccr = 3'b010;
        idle_cycle();

        // Flush at BUSY cnt==2: no result, CCR untouched, next issue accepted.
        @(negedge clk);
        issue_valid = 1'b1; issue_op = 3'd5; issue_multi = 1'b1; issue_shamt = 4'd4;
        issue_flag_we = 1'b1; op_a = 16'h0001;
        #1 chk("fl_stall0", 32'(stall), 32'd1);
        @(negedge clk);
        issue_valid = 1'b0;
        #1 chk("fl_stall1", 32'(stall), 32'd1);
        chk("fl_alu_a1", 32'(alu_a), 32'h0002);
        @(negedge clk);
        flush = 1'b1;
        #1 chk("fl_stall_flush", 32'(stall), 32'd0);
        @(posedge clk); #1;
        chk("fl_res_valid", 32'(res_valid), 32'd0);
        chk("fl_flags", 32'(flags), 32'(m_ccr));
        @(negedge clk);
        flush = 1'b0;
        #1 chk("fl_stall_after", 32'(stall), 32'd0);
        @(posedge clk); #1;
        chk("fl_res_valid_after", 32'(res_valid), 32'd0);
        run_instr(3'd0, 1'b0, 4'd0, 1'b1, 16'h0001, 16'h0001, 16'h0002, 3'b000, 0, 1'b0);
        m_ccr = 3'b000;

        // Asynchronous reset in the middle of a shift.
        @(negedge clk);
        issue_valid = 1'b1; issue_op = 3'd5; issue_multi = 1'b1; issue_shamt = 4'd5;
        issue_flag_we = 1'b1; op_a = 16'h0003;
        @(negedge clk);
        issue_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mr_stall", 32'(stall), 32'd0);
        chk("mr_alu_op", 32'(alu_op), 32'd0);
        chk("mr_alu_a", 32'(alu_a), 32'd0);
        chk("mr_alu_b", 32'(alu_b), 32'd0);
        chk("mr_res_valid", 32'(res_valid), 32'd0);
        chk("mr_res_data", 32'(res_data), 32'd0);
        chk("mr_flags", 32'(flags), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        m_ccr = 3'b000;
        run_instr(3'd3, 1'b0, 4'd0, 1'b1, 16'h8000, 16'h0001, 16'h8001, 3'b010, 0, 1'b0);
        m_ccr = 3'b010;

`ifdef EXEC_CCR_SHADOW_EN
        run_instr(3'd0, 1'b0, 4'd0, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 3'b101, 0, 1'b0);
        @(negedge clk);
        issue_valid = 1'b0; ccr_save = 1'b1;
        @(negedge clk);
        ccr_save = 1'b0;
        run_instr(3'd4, 1'b0, 4'd0, 1'b1, 16'hF0F0, 16'h0FF0, 16'hFF00, 3'b010, 0, 1'b0);
        @(negedge clk);
        issue_valid = 1'b0; ccr_restore = 1'b1;
        @(posedge clk); #1;
        chk("sh_restore", 32'(flags), 32'b101);
        @(negedge clk);
        ccr_restore = 1'b0;
        run_instr(3'd0, 1'b0, 4'd0, 1'b1, 16'h0003, 16'h0005, 16'h0008, 3'b000, 0, 1'b0);
        @(negedge clk);
        issue_valid = 1'b1; issue_op = 3'd4; issue_multi = 1'b0; issue_flag_we = 1'b1;
        op_a = 16'hF0F0; op_b = 16'h0FF0; ccr_restore = 1'b1;
        @(posedge clk); #1;
        chk("sh_restore_wins", 32'(flags), 32'b101);
        chk("sh_res_valid", 32'(res_valid), 32'd1);
        @(negedge clk);
        ccr_restore = 1'b0; issue_valid = 1'b0;
        m_ccr = 3'b101;
        @(posedge clk); #1;
`endif

        // Randomized instructions against the reference model.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 4) == 0) idle_cycle();
            else rand_instr();
        end
        idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
